// File: rtl/axis_eth_fcs_check.sv
// Receive-side Ethernet FCS checker/stripper; AXIS_ETH_FCS_CHECK_STATS_EN adds frame/bad-FCS counters.
// Byte k leaves one cycle after byte k+4 is accepted; s_axis_tready = m_axis_tready | ~m_axis_tvalid.
module axis_eth_fcs_check #(
   parameter int MIN_FRAME_LENGTH = 64,
   parameter int STATS_WIDTH      = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   input  logic       s_axis_tuser,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       m_axis_tlast,
   output logic       m_axis_tuser,
   output logic       error_bad_fcs,
   output logic       error_bad_frame
`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
   ,
   output logic [STATS_WIDTH-1:0] stat_frames,
   output logic [STATS_WIDTH-1:0] stat_bad_fcs
`endif
);

   localparam logic [31:0] MIN_LEN  = MIN_FRAME_LENGTH;
   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

   // Reflected CRC-32 (poly 04C11DB7 bit-reversed), one byte per call, LSB first.
   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc ^ {24'd0, b};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction

   logic [3:0][7:0] dl_q, dl_d;
   logic [2:0]      fill_q, fill_d;
   logic [31:0]     crc_q, crc_d;
   logic [15:0]     len_q, len_d;
   logic            sticky_q, sticky_d;
   logic [7:0]      m_tdata_q, m_tdata_d;
   logic            m_tvalid_q, m_tvalid_d;
   logic            m_tlast_q, m_tlast_d;
   logic            m_tuser_q, m_tuser_d;
   logic            bad_fcs_q, bad_fcs_d;
   logic            bad_frame_q, bad_frame_d;

   logic            accept;
   logic            full;
   logic [31:0]     crc_nxt;
   logic [31:0]     rx_fcs;
   logic            mismatch;
   logic            sticky_all;
   logic            short_frame;

`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
   logic [STATS_WIDTH-1:0] stat_frames_q, stat_frames_d;
   logic [STATS_WIDTH-1:0] stat_bad_fcs_q, stat_bad_fcs_d;
`endif

   assign s_axis_tready = m_axis_tready | ~m_tvalid_q;
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign full          = (fill_q == 3'd4);
   assign crc_nxt       = crc_byte(crc_q, dl_q[3]);
   // dl_q[0] is the newest byte, so on tlast dl_q[2..0] hold FCS bytes 0..2.
   assign rx_fcs        = {s_axis_tdata, dl_q[0], dl_q[1], dl_q[2]};
   assign mismatch      = (~crc_nxt != rx_fcs);
   assign sticky_all    = sticky_q | s_axis_tuser;
   assign short_frame   = (({16'd0, len_q} + 32'd1) < MIN_LEN);

   always_comb begin
      dl_d        = dl_q;
      fill_d      = fill_q;
      crc_d       = crc_q;
      len_d       = len_q;
      sticky_d    = sticky_q;
      m_tdata_d   = m_tdata_q;
      m_tvalid_d  = m_tvalid_q;
      m_tlast_d   = m_tlast_q;
      m_tuser_d   = m_tuser_q;
      bad_fcs_d   = 1'b0;
      bad_frame_d = 1'b0;
`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
      stat_frames_d  = stat_frames_q;
      stat_bad_fcs_d = stat_bad_fcs_q;
`endif
      if (m_axis_tready) begin
         m_tvalid_d = 1'b0;
      end
      if (accept) begin
         dl_d     = {dl_q[2:0], s_axis_tdata};
         len_d    = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
         sticky_d = sticky_all;
         if (full) begin
            m_tdata_d  = dl_q[3];
            m_tvalid_d = 1'b1;
            m_tlast_d  = s_axis_tlast;
            m_tuser_d  = s_axis_tlast & (mismatch | sticky_all | short_frame);
            crc_d      = crc_nxt;
         end else begin
            fill_d = fill_q + 3'd1;
         end
         if (s_axis_tlast) begin
            fill_d      = 3'd0;
            crc_d       = CRC_INIT;
            len_d       = 16'd0;
            sticky_d    = 1'b0;
            bad_fcs_d   = full & mismatch;
            bad_frame_d = ~full | sticky_all | short_frame;
`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
            stat_frames_d = stat_frames_q + 1'b1;
            if (full & mismatch) begin
               stat_bad_fcs_d = stat_bad_fcs_q + 1'b1;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dl_q        <= '0;
         fill_q      <= 3'd0;
         crc_q       <= CRC_INIT;
         len_q       <= 16'd0;
         sticky_q    <= 1'b0;
         m_tdata_q   <= 8'd0;
         m_tvalid_q  <= 1'b0;
         m_tlast_q   <= 1'b0;
         m_tuser_q   <= 1'b0;
         bad_fcs_q   <= 1'b0;
         bad_frame_q <= 1'b0;
`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
         stat_frames_q  <= '0;
         stat_bad_fcs_q <= '0;
`endif
      end else begin
         dl_q        <= dl_d;
         fill_q      <= fill_d;
         crc_q       <= crc_d;
         len_q       <= len_d;
         sticky_q    <= sticky_d;
         m_tdata_q   <= m_tdata_d;
         m_tvalid_q  <= m_tvalid_d;
         m_tlast_q   <= m_tlast_d;
         m_tuser_q   <= m_tuser_d;
         bad_fcs_q   <= bad_fcs_d;
         bad_frame_q <= bad_frame_d;
`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
         stat_frames_q  <= stat_frames_d;
         stat_bad_fcs_q <= stat_bad_fcs_d;
`endif
      end
   end

   assign m_axis_tdata    = m_tdata_q;
   assign m_axis_tvalid   = m_tvalid_q;
   assign m_axis_tlast    = m_tlast_q;
   assign m_axis_tuser    = m_tuser_q;
   assign error_bad_fcs   = bad_fcs_q;
   assign error_bad_frame = bad_frame_q;
`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
   assign stat_frames  = stat_frames_q;
   assign stat_bad_fcs = stat_bad_fcs_q;
`endif

endmodule

// File: tb/tb_axis_eth_fcs_check.sv
// Directed bench for axis_eth_fcs_check: CRC-32 check vector "123456789" framed with its FCS.
module tb_axis_eth_fcs_check;
   localparam int MINLEN = 13;
   localparam int SW     = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_tdata = 8'd0;
   logic       s_tvalid = 1'b0;
   logic       s_tready;
   logic       s_tlast = 1'b0;
   logic       s_tuser = 1'b0;
   logic [7:0] m_tdata;
   logic       m_tvalid;
   logic       m_tready = 1'b1;
   logic       m_tlast;
   logic       m_tuser;
   logic       err_fcs;
   logic       err_frame;
`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
   logic [SW-1:0] stat_frames;
   logic [SW-1:0] stat_bad_fcs;
`endif

   always #5 clk = ~clk;

   axis_eth_fcs_check #(.MIN_FRAME_LENGTH(MINLEN), .STATS_WIDTH(SW)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
      .error_bad_fcs(err_fcs), .error_bad_frame(err_frame)
`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
      , .stat_frames(stat_frames), .stat_bad_fcs(stat_bad_fcs)
`endif
   );

   int vec = 0;
   int miscmp = 0;
   int frames_acc = 0;

   // "123456789" followed by its FCS CBF43926, least significant byte first.
   logic [7:0] gf [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                           8'h26, 8'h39, 8'hF4, 8'hCB};

   logic [7:0] stim_b [$];
   bit         stim_l [$];
   bit         stim_u [$];

   logic [7:0] got_dat  [$];
   bit         got_last [$];
   bit         got_user [$];
   int         n_fcs = 0;
   int         n_frame = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (m_tvalid && m_tready) begin
            got_dat.push_back(m_tdata);
            got_last.push_back(m_tlast);
            got_user.push_back(m_tuser);
         end
         if (err_fcs)   n_fcs++;
         if (err_frame) n_frame++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic add_good(input logic [7:0] fcs3, input int err_idx);
      for (int k = 0; k < 13; k++) begin
         stim_b.push_back(k == 12 ? fcs3 : gf[k]);
         stim_l.push_back(k == 12);
         stim_u.push_back(k == err_idx);
      end
   endtask

   task automatic drive(input bit gaps, input bit toggle);
      int i = 0;
      int cyc = 0;
      bit acc;
      while (i < stim_b.size() && cyc < 2000) begin
         if (toggle) m_tready = ~m_tready;
         if (gaps && $urandom_range(0, 2) == 0) begin
            s_tvalid = 1'b0;
         end else begin
            s_tvalid = 1'b1;
            s_tdata  = stim_b[i];
            s_tlast  = stim_l[i];
            s_tuser  = stim_u[i];
         end
         @(negedge clk);
         acc = s_tvalid && s_tready;
         @(posedge clk); #1;
         if (acc) begin
            if (s_tlast) frames_acc++;
            i++;
         end
         cyc++;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; m_tready = 1'b1;
      vec++;
      if (i != stim_b.size()) begin
         miscmp++;
         $display("FAIL drive_timeout: accepted %0d beats, required %0d", i, stim_b.size());
      end
      repeat (6) @(posedge clk);
      #1;
      stim_b.delete(); stim_l.delete(); stim_u.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      vec++; if (m_tvalid !== 1'b0) begin miscmp++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
      vec++; if (m_tlast !== 1'b0) begin miscmp++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
      vec++; if (m_tuser !== 1'b0) begin miscmp++; $display("FAIL reset_tuser: got %b want 0", m_tuser); end
      vec++; if ({err_fcs, err_frame} !== 2'b00) begin miscmp++; $display("FAIL reset_err: got %b%b want 00", err_fcs, err_frame); end
      vec++; if (s_tready !== 1'b1) begin miscmp++; $display("FAIL reset_tready: got %b want 1", s_tready); end
`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
      vec++; if (stat_frames !== '0 || stat_bad_fcs !== '0) begin miscmp++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_frames, stat_bad_fcs); end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_good_frame();
      int base = got_dat.size(); int f0 = n_fcs; int b0 = n_frame; int n;
      add_good(8'hCB, -1);
      drive(1'b0, 1'b0);
      n = got_dat.size() - base;
      vec++; if (n != 9) begin miscmp++; $display("FAIL good_count: got %0d beats want 9", n); end
      for (int k = 0; k < 9 && k < n; k++) begin
         vec++;
         if (got_dat[base+k] !== gf[k] || got_last[base+k] !== (k == 8)) begin
            miscmp++; $display("FAIL good_beat%0d: got %h/last %b want %h/last %b", k, got_dat[base+k], got_last[base+k], gf[k], k == 8);
         end
      end
      vec++; if (n < 1 || got_user[base+n-1] !== 1'b0) begin miscmp++; $display("FAIL good_tuser: got %b want 0", n > 0 ? got_user[base+n-1] : 1'b1); end
      vec++; if (n_fcs - f0 != 0 || n_frame - b0 != 0) begin miscmp++; $display("FAIL good_pulses: got fcs %0d frame %0d want 0 0", n_fcs - f0, n_frame - b0); end
   endtask

   task automatic test_bad_fcs();
      int base = got_dat.size(); int f0 = n_fcs; int b0 = n_frame; int n;
      add_good(8'hCA, -1);
      drive(1'b0, 1'b0);
      n = got_dat.size() - base;
      vec++; if (n != 9) begin miscmp++; $display("FAIL badfcs_count: got %0d beats want 9", n); end
      vec++; if (n < 1 || got_user[base+n-1] !== 1'b1 || got_last[base+n-1] !== 1'b1) begin miscmp++; $display("FAIL badfcs_tuser: got user/last %b/%b want 1/1", n > 0 ? got_user[base+n-1] : 1'b0, n > 0 ? got_last[base+n-1] : 1'b0); end
      vec++; if (n_fcs - f0 != 1) begin miscmp++; $display("FAIL badfcs_pulse: got %0d want 1", n_fcs - f0); end
      vec++; if (n_frame - b0 != 0) begin miscmp++; $display("FAIL badfcs_frame_pulse: got %0d want 0", n_frame - b0); end
   endtask

   task automatic test_runt_back_to_back();
      int base = got_dat.size(); int f0 = n_fcs; int b0 = n_frame; int n;
      stim_b = '{8'hAA, 8'hBB, 8'hCC};
      stim_l = '{1'b0, 1'b0, 1'b1};
      stim_u = '{1'b0, 1'b0, 1'b0};
      add_good(8'hCB, -1);
      drive(1'b0, 1'b0);
      n = got_dat.size() - base;
      vec++; if (n != 9) begin miscmp++; $display("FAIL runt_count: got %0d beats want 9 (good frame only)", n); end
      for (int k = 0; k < 9 && k < n; k++) begin
         vec++;
         if (got_dat[base+k] !== gf[k]) begin miscmp++; $display("FAIL runt_beat%0d: got %h want %h", k, got_dat[base+k], gf[k]); end
      end
      vec++; if (n < 1 || got_user[base+n-1] !== 1'b0) begin miscmp++; $display("FAIL runt_next_tuser: got %b want 0", n > 0 ? got_user[base+n-1] : 1'b1); end
      vec++; if (n_frame - b0 != 1) begin miscmp++; $display("FAIL runt_frame_pulse: got %0d want 1", n_frame - b0); end
      vec++; if (n_fcs - f0 != 0) begin miscmp++; $display("FAIL runt_fcs_pulse: got %0d want 0", n_fcs - f0); end
   endtask

   task automatic test_backpressure();
      int base = got_dat.size(); int f0 = n_fcs; int b0 = n_frame; int n;
      add_good(8'hCB, -1);
      drive(1'b1, 1'b1);
      n = got_dat.size() - base;
      vec++; if (n != 9) begin miscmp++; $display("FAIL bp_count: got %0d beats want 9", n); end
      for (int k = 0; k < 9 && k < n; k++) begin
         vec++;
         if (got_dat[base+k] !== gf[k] || got_last[base+k] !== (k == 8)) begin
            miscmp++; $display("FAIL bp_beat%0d: got %h/last %b want %h/last %b", k, got_dat[base+k], got_last[base+k], gf[k], k == 8);
         end
      end
      vec++; if (n < 1 || got_user[base+n-1] !== 1'b0) begin miscmp++; $display("FAIL bp_tuser: got %b want 0", n > 0 ? got_user[base+n-1] : 1'b1); end
      vec++; if (n_fcs - f0 != 0 || n_frame - b0 != 0) begin miscmp++; $display("FAIL bp_pulses: got fcs %0d frame %0d want 0 0", n_fcs - f0, n_frame - b0); end
   endtask

   task automatic test_upstream_err();
      int base = got_dat.size(); int f0 = n_fcs; int b0 = n_frame; int n;
      add_good(8'hCB, 2);
      drive(1'b0, 1'b0);
      n = got_dat.size() - base;
      vec++; if (n != 9) begin miscmp++; $display("FAIL uerr_count: got %0d beats want 9", n); end
      vec++; if (n < 1 || got_user[base+n-1] !== 1'b1) begin miscmp++; $display("FAIL uerr_tuser: got %b want 1", n > 0 ? got_user[base+n-1] : 1'b0); end
      vec++; if (n_frame - b0 != 1) begin miscmp++; $display("FAIL uerr_frame_pulse: got %0d want 1", n_frame - b0); end
      vec++; if (n_fcs - f0 != 0) begin miscmp++; $display("FAIL uerr_fcs_pulse: got %0d want 0", n_fcs - f0); end
   endtask

`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
   task automatic test_stats();
      vec++; if (stat_frames !== SW'(frames_acc)) begin miscmp++; $display("FAIL stat_frames: got %0d want %0d", stat_frames, frames_acc); end
      vec++; if (stat_bad_fcs !== SW'(1)) begin miscmp++; $display("FAIL stat_bad_fcs: got %0d want 1", stat_bad_fcs); end
   endtask
`endif

   task automatic test_reset_midframe();
      int base = got_dat.size(); int b0 = n_frame; int n;
      m_tready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         s_tvalid = 1'b1; s_tdata = gf[k]; s_tlast = 1'b0; s_tuser = 1'b0;
         @(posedge clk); #1;
      end
      s_tvalid = 1'b0;
      vec++; if (m_tvalid !== 1'b1) begin miscmp++; $display("FAIL abort_pending: got tvalid %b want 1", m_tvalid); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      vec++; if (m_tvalid !== 1'b0) begin miscmp++; $display("FAIL abort_flush: got tvalid %b want 0", m_tvalid); end
      m_tready = 1'b1;
      add_good(8'hCB, -1);
      drive(1'b0, 1'b0);
      n = got_dat.size() - base;
      vec++; if (n != 9) begin miscmp++; $display("FAIL abort_count: got %0d beats want 9", n); end
      for (int k = 0; k < 9 && k < n; k++) begin
         vec++;
         if (got_dat[base+k] !== gf[k]) begin miscmp++; $display("FAIL abort_beat%0d: got %h want %h", k, got_dat[base+k], gf[k]); end
      end
      vec++; if (n < 1 || got_user[base+n-1] !== 1'b0) begin miscmp++; $display("FAIL abort_tuser: got %b want 0", n > 0 ? got_user[base+n-1] : 1'b1); end
      vec++; if (n_frame - b0 != 0) begin miscmp++; $display("FAIL abort_frame_pulse: got %0d want 0", n_frame - b0); end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_fcs();
      test_runt_back_to_back();
      test_backpressure();
      test_upstream_err();
`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
      test_stats();
`endif
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end

endmodule
